// File: rtl/spi_cmd_if.sv
// Bus-side request/completion signals between spi_cmd (master) and the
// system bus arbiter (slave).
interface spi_cmd_if;
  logic [15:0] spi_addr;
  logic [7:0]  spi_data_out;
  logic        spi_we;
  logic        spi_pending;
  logic        spi_done;
  logic [7:0]  spi_data_in;

  modport master (
    output spi_addr, spi_data_out, spi_we, spi_pending,
    input  spi_done, spi_data_in
  );

  modport slave (
    input  spi_addr, spi_data_out, spi_we, spi_pending,
    output spi_done, spi_data_in
  );
endinterface

// File: rtl/spi_cmd.sv
// SPI command framer: turns received bytes into single bus reads/writes with
// auto-increment. Optional status byte on tx_byte with `define SPI_CMD_STATUS_EN.
module spi_cmd (
  input  logic       sys_clk,
  input  logic       reset_n,
  input  logic       spi_cs_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic [7:0] tx_byte,
  output logic       overrun,
  spi_cmd_if.master  bus
);

  typedef enum logic [2:0] {
    CMD, ADDR_HI, ADDR_LO, WRITE, READ, IGNORE
  } state_t;

  state_t      state_q, state_n;
  logic        op_write_q, op_write_n;
  logic [7:0]  tx_q, tx_n;
  logic [15:0] addr_q, addr_n;
  logic [7:0]  data_q, data_n;
  logic        we_q, we_n;
  logic        pending_q, pending_n;
  logic        overrun_q, overrun_n;
  logic        rx_valid_q;
  logic        cs_meta, cs_sync, cs_sync_q;

  logic byte_evt, cs_start, cs_end, completion;

  assign byte_evt   = rx_valid & ~rx_valid_q;
  assign cs_start   = cs_sync_q & ~cs_sync;
  assign cs_end     = ~cs_sync_q & cs_sync;
  assign completion = pending_q & bus.spi_done;

  // NOTE: every register is reset, including the cs_n synchronizer, which
  // resets to 1 (deselected) so that leaving reset never fakes a cs_start.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_meta    <= 1'b1;
      cs_sync    <= 1'b1;
      cs_sync_q  <= 1'b1;
      rx_valid_q <= 1'b0;
      state_q    <= CMD;
      op_write_q <= 1'b0;
      tx_q       <= 8'h00;
      addr_q     <= 16'h0000;
      data_q     <= 8'h00;
      we_q       <= 1'b0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here; all next values come from the
      // always_comb block below, so ordering inside this block is irrelevant.
      cs_meta    <= spi_cs_n;
      cs_sync    <= cs_meta;
      cs_sync_q  <= cs_sync;
      rx_valid_q <= rx_valid;
      state_q    <= state_n;
      op_write_q <= op_write_n;
      tx_q       <= tx_n;
      addr_q     <= addr_n;
      data_q     <= data_n;
      we_q       <= we_n;
      pending_q  <= pending_n;
      overrun_q  <= overrun_n;
    end
  end

  // NOTE: every next-value starts as a copy of its register, so no path
  // through the case statement can leave one unassigned (no latches).
  always_comb begin
    state_n    = state_q;
    op_write_n = op_write_q;
    tx_n       = tx_q;
    addr_n     = addr_q;
    data_n     = data_q;
    we_n       = we_q;
    pending_n  = pending_q;
    overrun_n  = overrun_q;

    // Completion is applied before the byte so a same-cycle byte is accepted.
    if (completion) begin
      pending_n = 1'b0;
      addr_n    = addr_q + 16'd1;
      if (!we_q) tx_n = bus.spi_data_in;
    end

    if (cs_end) begin
      state_n = CMD;
    end else if (byte_evt) begin
      if (pending_n) begin
        overrun_n = 1'b1;
      end else begin
        unique case (state_q)
          CMD: begin
            if (rx_byte == 8'h80) begin
              op_write_n = 1'b1;
              state_n    = ADDR_HI;
            end else if (rx_byte == 8'h40) begin
              op_write_n = 1'b0;
              state_n    = ADDR_HI;
            end else begin
              state_n    = IGNORE;
            end
          end
          ADDR_HI: begin
            addr_n[15:8] = rx_byte;
            state_n      = ADDR_LO;
          end
          ADDR_LO: begin
            addr_n[7:0] = rx_byte;
            if (op_write_q) begin
              state_n = WRITE;
            end else begin
              we_n      = 1'b0;
              pending_n = 1'b1;
              state_n   = READ;
            end
          end
          WRITE: begin
            data_n    = rx_byte;
            we_n      = 1'b1;
            pending_n = 1'b1;
          end
          READ: begin
            we_n      = 1'b0;
            pending_n = 1'b1;
          end
          IGNORE: ;
          default: state_n = CMD;
        endcase
      end
    end

    if (cs_start) overrun_n = 1'b0;
  end

`ifdef SPI_CMD_STATUS_EN
  // Status is shown while the master is still clocking out command/address.
  assign tx_byte = (state_q == CMD || state_q == ADDR_HI || state_q == ADDR_LO)
                 ? {overrun_q, pending_q, 6'b0} : tx_q;
`else
  assign tx_byte = tx_q;
`endif

  assign overrun          = overrun_q;
  assign bus.spi_addr     = addr_q;
  assign bus.spi_data_out = data_q;
  assign bus.spi_we       = we_q;
  assign bus.spi_pending  = pending_q;

endmodule
